// File: rtl/iir_sched_pkg.sv
// Shared types, widths and arithmetic helpers for the time-shared IIR channel scheduler.
package iir_sched_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned PROD_W = 32;
  localparam int unsigned ACC_W  = 34;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_EMIT = 2'd2
  } state_e;

  // Bilinear coefficients for time constant T: A = 1+2T, B = 1-2T.
  function automatic logic signed [DATA_W-1:0] coef_a(input int t);
    return DATA_W'(1 + 2 * t);
  endfunction

  function automatic logic signed [DATA_W-1:0] coef_b(input int t);
    return DATA_W'(1 - 2 * t);
  endfunction

  // Clamp the full-precision accumulator into the signed 16-bit sample range.
  function automatic logic signed [DATA_W-1:0] sat16(input logic signed [ACC_W-1:0] acc);
    if (acc > 34'sd32767) begin
      return 16'sh7fff;
    end else if (acc < -34'sd32768) begin
      return 16'sh8000;
    end else begin
      return acc[DATA_W-1:0];
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester strictly after last_grant wins.
module rr_arbiter #(
  parameter int unsigned NUM_CH = 4,
  localparam int unsigned IDX_W = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  last_grant,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx
);

  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      cand = IDX_W'((32'(last_grant) + i) % NUM_CH);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/iir_channel_scheduler.sv
// Shares one first-order bilinear IIR datapath across NUM_CH streams with per-channel state
// and a valid/ready result port.
module iir_channel_scheduler
  import iir_sched_pkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int          TIMECONSTANT = 9,
  localparam int unsigned IDX_W       = $clog2(NUM_CH)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [NUM_CH-1:0]        req_valid_i,
  input  logic [NUM_CH*DATA_W-1:0] req_data_i,
  output logic [NUM_CH-1:0]        req_ready_o,
  input  logic [NUM_CH-1:0]        clear_ch_i,
  output logic                     out_valid_o,
  output logic signed [DATA_W-1:0] out_data_o,
  output logic [IDX_W-1:0]         out_ch_o,
  input  logic                     out_ready_i,
  output logic                     busy_o
);

  localparam logic signed [DATA_W-1:0] COEF_A = coef_a(TIMECONSTANT);
  localparam logic signed [DATA_W-1:0] COEF_B = coef_b(TIMECONSTANT);

  state_e state;
  state_e state_next;

  logic [NUM_CH-1:0]        grant;
  logic [IDX_W-1:0]         grant_idx;
  logic [IDX_W-1:0]         last_grant;
  logic [IDX_W-1:0]         ch_reg;
  logic signed [DATA_W-1:0] grant_data;
  logic signed [DATA_W-1:0] x_reg;
  logic signed [DATA_W-1:0] x_prev [NUM_CH];
  logic signed [DATA_W-1:0] y_prev [NUM_CH];
  logic signed [DATA_W-1:0] x_cur;
  logic signed [DATA_W-1:0] y_cur;
  logic signed [PROD_W-1:0] prod_a;
  logic signed [PROD_W-1:0] prod_b;
  logic signed [ACC_W-1:0]  acc;
  logic signed [DATA_W-1:0] y_sat;
  logic                     accept;
  logic                     calc_wr;
  logic                     xfer;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req        (req_valid_i),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  // Select the granted channel's sample from the flattened input bus.
  always_comb begin
    grant_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant[k]) begin
        grant_data = req_data_i[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    calc_wr     = 1'b0;
    xfer        = 1'b0;
    req_ready_o = '0;
    unique case (state)
      ST_IDLE: begin
        if (|req_valid_i) begin
          accept      = 1'b1;
          req_ready_o = grant;
          state_next  = ST_CALC;
        end
      end
      ST_CALC: begin
        calc_wr    = 1'b1;
        state_next = ST_EMIT;
      end
      ST_EMIT: begin
        if (out_valid_o && out_ready_i) begin
          xfer       = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // acc = A*x - B*x_prev - y_prev at full precision, then clamp.
  assign x_cur  = x_prev[ch_reg];
  assign y_cur  = y_prev[ch_reg];
  assign prod_a = PROD_W'(COEF_A) * PROD_W'(x_reg);
  assign prod_b = PROD_W'(COEF_B) * PROD_W'(x_cur);
  assign acc    = ACC_W'(prod_a) - ACC_W'(prod_b) - ACC_W'(y_cur);
  assign y_sat  = sat16(acc);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      x_reg       <= '0;
      ch_reg      <= '0;
      last_grant  <= IDX_W'(NUM_CH - 1);
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_ch_o    <= '0;
      busy_o      <= 1'b0;
    end else begin
      busy_o <= (state_next != ST_IDLE);
      if (accept) begin
        x_reg      <= grant_data;
        ch_reg     <= grant_idx;
        last_grant <= grant_idx;
      end
      if (calc_wr) begin
        out_data_o  <= y_sat;
        out_ch_o    <= ch_reg;
        out_valid_o <= 1'b1;
      end else if (xfer) begin
        out_valid_o <= 1'b0;
      end
    end
  end

  // Per-channel filter state; a clear beats a same-cycle writeback.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (reset_i || clear_ch_i[k]) begin
        x_prev[k] <= '0;
        y_prev[k] <= '0;
      end else if (calc_wr && (ch_reg == IDX_W'(k))) begin
        x_prev[k] <= x_reg;
        y_prev[k] <= y_sat;
      end
    end
  end

endmodule

// File: tb/tb_iir_channel_scheduler.sv
// Self-checking bench for iir_channel_scheduler: directed vector table, hand-written corner
// sequences and a randomized run against a transaction-level reference model.
module tb_iir_channel_scheduler;

  localparam int NCH = 4;
  localparam int T   = 9;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NCH-1:0]       req_valid;
  logic [NCH*16-1:0]    req_data;
  logic [NCH-1:0]       req_ready;
  logic [NCH-1:0]       clear_ch;
  logic                 out_valid;
  logic signed [15:0]   out_data;
  logic [1:0]           out_ch;
  logic                 out_ready;
  logic                 busy;

  int checks   = 0;
  int failures = 0;

  int m_xp [NCH];
  int m_yp [NCH];
  int m_last;
  int grant_log [$];

  typedef struct {
    int ch;
    int x;
    bit pre_clear;
    bit mid_clear;
    int exp_y;
  } vec_t;

  vec_t vecs [8];

  iir_channel_scheduler #(.NUM_CH(NCH), .TIMECONSTANT(T)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .clear_ch_i  (clear_ch),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_ch_o    (out_ch),
    .out_ready_i (out_ready),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference filter: y = sat(A*x - B*x_prev - y_prev) with A = 1+2T, B = 1-2T.
  function automatic int model_filter(input int ch, input int x);
    int a;
    int b;
    int acc;
    int y;
    a   = 1 + 2 * T;
    b   = 1 - 2 * T;
    acc = a * x - b * m_xp[ch] - m_yp[ch];
    y   = (acc > 32767) ? 32767 : ((acc < -32768) ? -32768 : acc);
    m_xp[ch] = x;
    m_yp[ch] = y;
    return y;
  endfunction

  function automatic int model_grant(input logic [NCH-1:0] v);
    for (int i = 1; i <= NCH; i++) begin
      if (v[(m_last + i) % NCH]) return (m_last + i) % NCH;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_xp[k] = 0;
      m_yp[k] = 0;
    end
    m_last = NCH - 1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    clear_ch  = '0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    model_reset();
  endtask

  // Single-channel transaction with latency, handshake and value checks.
  task automatic run_vec(input vec_t v);
    int waited;
    if (v.pre_clear) begin
      clear_ch       = '0;
      clear_ch[v.ch] = 1'b1;
      tick();
      clear_ch = '0;
    end
    req_valid                 = '0;
    req_valid[v.ch]           = 1'b1;
    req_data[v.ch*16 +: 16]   = 16'(v.x);
    out_ready                 = 1'b1;
    #1;
    waited = 0;
    while (req_ready == '0 && waited < 20) begin
      tick();
      #1;
      waited++;
    end
    check("vec_ready", int'(req_ready), 1 << v.ch);
    tick();
    req_valid = '0;
    if (v.mid_clear) clear_ch[v.ch] = 1'b1;
    check("vec_calc_valid", int'(out_valid), 0);
    check("vec_calc_busy", int'(busy), 1);
    check("vec_calc_ready", int'(req_ready), 0);
    tick();
    clear_ch = '0;
    check("vec_emit_valid", int'(out_valid), 1);
    check("vec_data", int'(out_data), v.exp_y);
    check("vec_ch", int'(out_ch), v.ch);
    tick();
    check("vec_post_valid", int'(out_valid), 0);
  endtask

  // Cycle-by-cycle run with random (or all-valid) requesters checked against the model.
  task automatic run_engine(input int ncyc, input bit all_valid);
    bit             pend;
    bit             xfer;
    int             age;
    int             pend_ch;
    int             pend_y;
    int             g;
    logic [NCH-1:0] hold;
    pend = 1'b0;
    age = 0;
    pend_ch = 0;
    pend_y = 0;
    hold = '0;
    grant_log.delete();
    for (int c = 0; c < ncyc; c++) begin
      for (int k = 0; k < NCH; k++) begin
        if (!hold[k] && (all_valid || $urandom_range(0, 2) == 0)) begin
          hold[k]              = 1'b1;
          req_data[k*16 +: 16] = 16'($urandom_range(0, 65535));
        end
      end
      req_valid = hold;
      out_ready = all_valid ? 1'b1 : ($urandom_range(0, 3) != 0);
      #1;
      g = pend ? -1 : model_grant(hold);
      check("eng_ready", int'(req_ready), (g < 0) ? 0 : (1 << g));
      check("eng_busy", int'(busy), int'(pend));
      check("eng_valid", int'(out_valid), int'(pend && age >= 2));
      if (pend && age >= 2) begin
        check("eng_data", int'(out_data), pend_y);
        check("eng_ch", int'(out_ch), pend_ch);
      end
      xfer = pend && (age >= 2) && out_ready;
      if (g >= 0) begin
        pend_y  = model_filter(g, int'($signed(req_data[g*16 +: 16])));
        pend_ch = g;
        m_last  = g;
        hold[g] = 1'b0;
        grant_log.push_back(g);
      end
      tick();
      if (pend) begin
        if (xfer) pend = 1'b0;
        else age++;
      end
      if (g >= 0) begin
        pend = 1'b1;
        age  = 1;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{ch: 0, x: 100,   pre_clear: 1'b0, mid_clear: 1'b0, exp_y: 1900};
    vecs[1] = '{ch: 0, x: 100,   pre_clear: 1'b0, mid_clear: 1'b0, exp_y: 1700};
    vecs[2] = '{ch: 0, x: 100,   pre_clear: 1'b0, mid_clear: 1'b0, exp_y: 1900};
    vecs[3] = '{ch: 1, x: 2000,  pre_clear: 1'b1, mid_clear: 1'b0, exp_y: 32767};
    vecs[4] = '{ch: 1, x: -2000, pre_clear: 1'b1, mid_clear: 1'b0, exp_y: -32768};
    vecs[5] = '{ch: 0, x: 100,   pre_clear: 1'b1, mid_clear: 1'b0, exp_y: 1900};
    vecs[6] = '{ch: 0, x: 100,   pre_clear: 1'b0, mid_clear: 1'b1, exp_y: 1700};
    vecs[7] = '{ch: 0, x: 100,   pre_clear: 1'b0, mid_clear: 1'b0, exp_y: 1900};

    do_reset();
    #1;
    check("rst_ready", int'(req_ready), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_data", int'(out_data), 0);
    check("rst_ch", int'(out_ch), 0);
    check("rst_busy", int'(busy), 0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Round-robin fairness and state isolation with every channel requesting.
    do_reset();
    run_engine(18, 1'b1);
    check("rr_count", grant_log.size(), 6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++) begin
      check("rr_order", grant_log[i], i % NCH);
    end

    // Backpressure: result held stable for 5 cycles, then exactly one transfer.
    do_reset();
    req_valid[2]          = 1'b1;
    req_data[2*16 +: 16]  = 16'(500);
    #1;
    check("bp_grant", int'(req_ready), 4);
    tick();
    req_valid            = '0;
    req_valid[3]         = 1'b1;
    req_data[3*16 +: 16] = 16'(7);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", int'(out_valid), 1);
      check("bp_data", int'(out_data), 9500);
      check("bp_ch", int'(out_ch), 2);
      check("bp_ready", int'(req_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_xfer_valid", int'(out_valid), 1);
    tick();
    check("bp_after_valid", int'(out_valid), 0);
    check("bp_next_grant", int'(req_ready), 8);
    tick();
    req_valid = '0;
    tick();
    check("bp_next_data", int'(out_data), 133);
    check("bp_next_ch", int'(out_ch), 3);
    tick();

    // Reset while a result is pending.
    do_reset();
    run_vec('{ch: 0, x: 100, pre_clear: 1'b0, mid_clear: 1'b0, exp_y: 1900});
    out_ready            = 1'b0;
    req_valid            = '0;
    req_valid[1]         = 1'b1;
    req_data[1*16 +: 16] = 16'(1000);
    tick();
    req_valid = '0;
    tick();
    check("mr_emit_valid", int'(out_valid), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    check("mr_valid", int'(out_valid), 0);
    check("mr_busy", int'(busy), 0);
    req_valid = '1;
    for (int k = 0; k < NCH; k++) req_data[k*16 +: 16] = 16'(100);
    #1;
    check("mr_grant", int'(req_ready), 1);
    tick();
    req_valid = '0;
    out_ready = 1'b1;
    tick();
    check("mr_out_valid", int'(out_valid), 1);
    check("mr_out_data", int'(out_data), 1900);
    check("mr_out_ch", int'(out_ch), 0);
    tick();

    // Randomized traffic with random backpressure.
    do_reset();
    run_engine(600, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
